// File: rtl/noc_depacketizer_pkg.sv
// Shared NoC definitions for the receive-side depacketizer: flit types, head-flit layout, FSM states.
// The head layout constants describe the default geometry; the depacketizer derives its own from its parameters.
package noc_depacketizer_pkg;

   localparam int DEF_FLIT_W  = 66;
   localparam int DEF_DATA_W  = 64;
   localparam int DEF_ID_X_W  = 2;
   localparam int DEF_ID_Y_W  = 2;
   localparam int DEF_TYPE_W  = 2;
   localparam int DEF_ORDER_W = 4;
   localparam int DEF_LEN_W   = 8;

   // Head flit fields packed from bit 0 upward.
   localparam int HEAD_SRC_X_LSB = 0;
   localparam int HEAD_SRC_Y_LSB = HEAD_SRC_X_LSB + DEF_ID_X_W;
   localparam int HEAD_DST_X_LSB = HEAD_SRC_Y_LSB + DEF_ID_Y_W;
   localparam int HEAD_DST_Y_LSB = HEAD_DST_X_LSB + DEF_ID_X_W;
   localparam int HEAD_TYPE_LSB  = HEAD_DST_Y_LSB + DEF_ID_Y_W;
   localparam int HEAD_ORDER_LSB = HEAD_TYPE_LSB + DEF_TYPE_W;
   localparam int HEAD_LEN_LSB   = HEAD_ORDER_LSB + DEF_ORDER_W;
   localparam int HEAD_W         = HEAD_LEN_LSB + DEF_LEN_W;

   typedef enum logic [1:0] {
      FLIT_BODY   = 2'b00,
      FLIT_TAIL   = 2'b01,
      FLIT_HEAD   = 2'b10,
      FLIT_SINGLE = 2'b11
   } flit_type_e;

   typedef struct packed {
      logic [DEF_LEN_W-1:0]   len;
      logic [DEF_ORDER_W-1:0] order;
      logic [DEF_TYPE_W-1:0]  pkt_type;
      logic [DEF_ID_Y_W-1:0]  dst_y;
      logic [DEF_ID_X_W-1:0]  dst_x;
      logic [DEF_ID_Y_W-1:0]  src_y;
      logic [DEF_ID_X_W-1:0]  src_x;
   } head_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_DROP    = 2'd2
   } state_e;

endpackage

// File: rtl/noc_skid_buf.sv
// Two-entry valid/ready skid buffer; entry 0 always drives the output.
module noc_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic [W-1:0] ent0;
   logic [W-1:0] ent1;
   logic [1:0]   count;
   logic         push;
   logic         pop;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign out_data  = ent0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // A push into a one-entry buffer while it drains lands directly in entry 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent0  <= '0;
         ent1  <= '0;
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) ent0 <= in_data;
               else               ent1 <= in_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               ent0  <= ent1;
               count <= count - 2'd1;
            end
            2'b11: ent0 <= in_data;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/noc_depacketizer.sv
// NoC local-port receiver: decodes head flits into metadata and strips payload flits into data beats.
// Optional destination/length checking is enabled with `NOC_DEPKT_CHECK_EN.
module noc_depacketizer
   import noc_depacketizer_pkg::*;
#(
   parameter int FLIT_W  = DEF_FLIT_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ID_X_W  = DEF_ID_X_W,
   parameter int ID_Y_W  = DEF_ID_Y_W,
   parameter int TYPE_W  = DEF_TYPE_W,
   parameter int ORDER_W = DEF_ORDER_W,
   parameter int LEN_W   = DEF_LEN_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ID_X_W-1:0]  local_x,
   input  logic [ID_Y_W-1:0]  local_y,
   input  logic               flit_in_valid,
   output logic               flit_in_ready,
   input  logic [FLIT_W-1:0]  flit_in,
   output logic               meta_valid,
   input  logic               meta_ready,
   output logic [ID_X_W-1:0]  meta_src_x,
   output logic [ID_Y_W-1:0]  meta_src_y,
   output logic [TYPE_W-1:0]  meta_type,
   output logic [ORDER_W-1:0] meta_order,
   output logic [LEN_W-1:0]   meta_len,
   output logic               data_valid,
   input  logic               data_ready,
   output logic [DATA_W-1:0]  data,
   output logic               data_last,
   output logic               err_dest,
   output logic               err_len,
   output logic               busy
);

   localparam int OFF_SRC_Y = ID_X_W;
   localparam int OFF_DST_X = OFF_SRC_Y + ID_Y_W;
   localparam int OFF_DST_Y = OFF_DST_X + ID_X_W;
   localparam int OFF_TYPE  = OFF_DST_Y + ID_Y_W;
   localparam int OFF_ORDER = OFF_TYPE + TYPE_W;
   localparam int OFF_LEN   = OFF_ORDER + ORDER_W;

   state_e           state;
   state_e           state_n;
   flit_type_e       ftype;
   logic             run;
   logic             accept;
   logic             dest_ok;
   logic             meta_load;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             push;
   logic             push_last;
   logic             err_len_n;
   logic [LEN_W:0]   cnt;
   logic [LEN_W:0]   cnt_next;
   logic             skid_in_ready;
   logic [DATA_W:0]  skid_in;
   logic [DATA_W:0]  skid_out;

   assign ftype    = flit_type_e'(flit_in[FLIT_W-1 -: 2]);
   assign cnt_next = (&cnt) ? cnt : cnt + {{LEN_W{1'b0}}, 1'b1};
   assign busy     = (state != ST_IDLE);

`ifdef NOC_DEPKT_CHECK_EN
   logic           err_dest_n;
   logic [LEN_W:0] len_plus1;

   assign dest_ok   = (flit_in[OFF_DST_X +: ID_X_W] == local_x) &&
                      (flit_in[OFF_DST_Y +: ID_Y_W] == local_y);
   assign len_plus1 = {1'b0, meta_len} + {{LEN_W{1'b0}}, 1'b1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_dest <= 1'b0;
      else     err_dest <= err_dest_n;
   end
`else
   logic unused_local;

   assign dest_ok      = 1'b1;
   assign err_dest     = 1'b0;
   assign unused_local = ^{local_x, local_y};
`endif

   // Ready is held off until the first cycle after reset so the reset value is 0.
   always_comb begin
      state_n       = state;
      flit_in_ready = 1'b0;
      meta_load     = 1'b0;
      cnt_clr       = 1'b0;
      cnt_inc       = 1'b0;
      push          = 1'b0;
      push_last     = 1'b0;
      err_len_n     = 1'b0;
`ifdef NOC_DEPKT_CHECK_EN
      err_dest_n    = 1'b0;
`endif
      case (state)
         ST_IDLE:    flit_in_ready = run && (!meta_valid || meta_ready);
         ST_PAYLOAD: flit_in_ready = run && skid_in_ready;
         ST_DROP:    flit_in_ready = run;
         default:    flit_in_ready = 1'b0;
      endcase
      accept = flit_in_valid && flit_in_ready;

      if (accept) begin
         case (state)
            ST_IDLE: begin
               case (ftype)
                  FLIT_HEAD: begin
                     if (dest_ok) begin
                        meta_load = 1'b1;
                        cnt_clr   = 1'b1;
                        state_n   = ST_PAYLOAD;
                     end else begin
`ifdef NOC_DEPKT_CHECK_EN
                        err_dest_n = 1'b1;
                        state_n    = ST_DROP;
`endif
                     end
                  end
                  FLIT_SINGLE: begin
                     if (dest_ok) begin
                        meta_load = 1'b1;
                     end else begin
`ifdef NOC_DEPKT_CHECK_EN
                        err_dest_n = 1'b1;
`endif
                     end
                  end
                  default: err_len_n = 1'b1;
               endcase
            end
            ST_PAYLOAD: begin
               push    = 1'b1;
               cnt_inc = 1'b1;
               if (ftype == FLIT_TAIL) begin
                  push_last = 1'b1;
                  state_n   = ST_IDLE;
`ifdef NOC_DEPKT_CHECK_EN
                  err_len_n = (cnt_next != len_plus1);
`endif
               end
            end
            ST_DROP: begin
               if (ftype == FLIT_TAIL) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   // Meta register holds its fields until the consumer takes them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         run        <= 1'b0;
         cnt        <= '0;
         err_len    <= 1'b0;
         meta_valid <= 1'b0;
         meta_src_x <= '0;
         meta_src_y <= '0;
         meta_type  <= '0;
         meta_order <= '0;
         meta_len   <= '0;
      end else begin
         state   <= state_n;
         run     <= 1'b1;
         err_len <= err_len_n;
         if (cnt_clr)      cnt <= '0;
         else if (cnt_inc) cnt <= cnt_next;
         if (meta_load) begin
            meta_valid <= 1'b1;
            meta_src_x <= flit_in[0 +: ID_X_W];
            meta_src_y <= flit_in[OFF_SRC_Y +: ID_Y_W];
            meta_type  <= flit_in[OFF_TYPE +: TYPE_W];
            meta_order <= flit_in[OFF_ORDER +: ORDER_W];
            meta_len   <= flit_in[OFF_LEN +: LEN_W];
         end else if (meta_ready) begin
            meta_valid <= 1'b0;
         end
      end
   end

   assign skid_in   = {push_last, flit_in[DATA_W-1:0]};
   assign data      = skid_out[DATA_W-1:0];
   assign data_last = skid_out[DATA_W];

   noc_skid_buf #(
      .W (DATA_W + 1)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (push),
      .in_ready  (skid_in_ready),
      .in_data   (skid_in),
      .out_valid (data_valid),
      .out_ready (data_ready),
      .out_data  (skid_out)
   );

endmodule

// File: tb/tb_noc_depacketizer.sv
// Directed self-checking bench for noc_depacketizer at node (1,2).
// Check-enabled scenarios run only when the bench is built with `NOC_DEPKT_CHECK_EN.
module tb_noc_depacketizer;
   import noc_depacketizer_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  local_x = 2'd1;
   logic [1:0]  local_y = 2'd2;
   logic        flit_in_valid = 1'b0;
   logic        flit_in_ready;
   logic [65:0] flit_in = '0;
   logic        meta_valid;
   logic        meta_ready = 1'b1;
   logic [1:0]  meta_src_x;
   logic [1:0]  meta_src_y;
   logic [1:0]  meta_type;
   logic [3:0]  meta_order;
   logic [7:0]  meta_len;
   logic        data_valid;
   logic        data_ready = 1'b1;
   logic [63:0] data;
   logic        data_last;
   logic        err_dest;
   logic        err_len;
   logic        busy;

   int total = 0;
   int bad = 0;
   int err_len_cnt = 0;
   int err_dest_cnt = 0;
   logic [64:0] beat_q[$];
   logic [17:0] meta_q[$];

   always #5 clk = ~clk;

   noc_depacketizer dut (
      .clk           (clk),
      .rst           (rst),
      .local_x       (local_x),
      .local_y       (local_y),
      .flit_in_valid (flit_in_valid),
      .flit_in_ready (flit_in_ready),
      .flit_in       (flit_in),
      .meta_valid    (meta_valid),
      .meta_ready    (meta_ready),
      .meta_src_x    (meta_src_x),
      .meta_src_y    (meta_src_y),
      .meta_type     (meta_type),
      .meta_order    (meta_order),
      .meta_len      (meta_len),
      .data_valid    (data_valid),
      .data_ready    (data_ready),
      .data          (data),
      .data_last     (data_last),
      .err_dest      (err_dest),
      .err_len       (err_len),
      .busy          (busy)
   );

   // Record every completed handshake and error pulse for later comparison.
   always @(posedge clk) begin
      if (!rst) begin
         if (data_valid && data_ready) beat_q.push_back({data_last, data});
         if (meta_valid && meta_ready)
            meta_q.push_back({meta_src_x, meta_src_y, meta_type, meta_order, meta_len});
         if (err_len)  err_len_cnt++;
         if (err_dest) err_dest_cnt++;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [65:0] mk_head(input flit_type_e kind, input logic [1:0] sx, input logic [1:0] sy,
                                           input logic [1:0] dx, input logic [1:0] dy, input logic [1:0] pt,
                                           input logic [3:0] ord, input logic [7:0] len);
      head_t h;
      h.src_x    = sx;
      h.src_y    = sy;
      h.dst_x    = dx;
      h.dst_y    = dy;
      h.pkt_type = pt;
      h.order    = ord;
      h.len      = len;
      return {kind, 42'd0, h};
   endfunction

   function automatic logic [65:0] mk_flit(input flit_type_e kind, input logic [63:0] payload);
      return {kind, payload};
   endfunction

   // Present one flit and hold it until accepted; returns 1 ns after the accepting edge.
   task automatic applyStimulus(input logic [65:0] f, input string tag);
      int wait_cyc = 0;
      flit_in       = f;
      flit_in_valid = 1'b1;
      @(negedge clk);
      while (!flit_in_ready && wait_cyc < 100) begin
         @(negedge clk);
         wait_cyc++;
      end
      if (!flit_in_ready) begin
         checkOutput({tag, "_accept_timeout"}, flit_in_ready, 1);
         flit_in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      flit_in_valid = 1'b0;
   endtask

   task automatic verifyBeats(input string tag, input int base, input int n, input logic [63:0] first);
      checkOutput({tag, "_beat_count"}, beat_q.size() - base, n);
      for (int i = 0; i < n; i++) begin
         if (base + i < beat_q.size()) begin
            checkOutput({tag, "_beat_data"}, beat_q[base + i][63:0], first + i);
            checkOutput({tag, "_beat_last"}, beat_q[base + i][64], (i == n - 1));
         end
      end
   endtask

   initial begin
      int beat_base;
      int meta_base;
      int elen_base;
      int edest_base;
      int low_at;

      #12;
      checkOutput("rst_flit_in_ready", flit_in_ready, 0);
      checkOutput("rst_meta_valid", meta_valid, 0);
      checkOutput("rst_data_valid", data_valid, 0);
      checkOutput("rst_data_last", data_last, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_err", {err_len, err_dest}, 0);
      checkOutput("rst_meta_len", meta_len, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("idle_flit_in_ready", flit_in_ready, 1);

      $display("[TB] basic packet len=3");
      beat_base = beat_q.size();
      meta_base = meta_q.size();
      elen_base = err_len_cnt;
      applyStimulus(mk_head(FLIT_HEAD, 2'd3, 2'd0, 2'd1, 2'd2, 2'd1, 4'd5, 8'd3), "t1_head");
      checkOutput("t1_meta_valid", meta_valid, 1);
      checkOutput("t1_meta_len", meta_len, 3);
      checkOutput("t1_busy", busy, 1);
      for (int i = 0; i < 4; i++)
         applyStimulus(mk_flit((i == 3) ? FLIT_TAIL : FLIT_BODY, 64'hA0 + i), "t1_payload");
      checkOutput("t1_tail_data", data, 64'hA3);
      checkOutput("t1_tail_last", data_last, 1);
      checkOutput("t1_busy_after_tail", busy, 0);
      repeat (4) @(posedge clk);
      #1;
      verifyBeats("t1", beat_base, 4, 64'hA0);
      checkOutput("t1_meta_count", meta_q.size() - meta_base, 1);
      if (meta_base < meta_q.size())
         checkOutput("t1_meta_fields", meta_q[meta_base], {2'd3, 2'd0, 2'd1, 4'd5, 8'd3});
      checkOutput("t1_err_len", err_len_cnt - elen_base, 0);

      $display("[TB] single flit packet");
      beat_base = beat_q.size();
      meta_base = meta_q.size();
      applyStimulus(mk_head(FLIT_SINGLE, 2'd2, 2'd1, 2'd1, 2'd2, 2'd3, 4'hA, 8'd0), "t2_single");
      checkOutput("t2_busy", busy, 0);
      checkOutput("t2_meta_type", meta_type, 3);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("t2_meta_count", meta_q.size() - meta_base, 1);
      if (meta_base < meta_q.size())
         checkOutput("t2_meta_fields", meta_q[meta_base], {2'd2, 2'd1, 2'd3, 4'hA, 8'd0});
      checkOutput("t2_beat_count", beat_q.size() - beat_base, 0);

      $display("[TB] data backpressure mid-packet");
      beat_base = beat_q.size();
      low_at    = -1;
      applyStimulus(mk_head(FLIT_HEAD, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 4'd1, 8'd7), "t3_head");
      fork
         begin
            for (int i = 0; i < 8; i++)
               applyStimulus(mk_flit((i == 7) ? FLIT_TAIL : FLIT_BODY, 64'hB0 + i), "t3_payload");
         end
         begin
            repeat (3) @(posedge clk);
            #2 data_ready = 1'b0;
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               if (!flit_in_ready && low_at < 0) low_at = i;
            end
            checkOutput("t3_ready_drop_within_2", (low_at >= 0 && low_at <= 2), 1);
            @(posedge clk);
            #2 data_ready = 1'b1;
         end
      join
      repeat (6) @(posedge clk);
      #1;
      verifyBeats("t3", beat_base, 8, 64'hB0);

`ifdef NOC_DEPKT_CHECK_EN
      $display("[TB] wrong destination packet");
      beat_base  = beat_q.size();
      meta_base  = meta_q.size();
      edest_base = err_dest_cnt;
      applyStimulus(mk_head(FLIT_HEAD, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 4'd0, 8'd2), "t4_head");
      checkOutput("t4_err_dest_pulse", err_dest, 1);
      checkOutput("t4_meta_valid", meta_valid, 0);
      checkOutput("t4_busy_drop", busy, 1);
      for (int i = 0; i < 3; i++)
         applyStimulus(mk_flit((i == 2) ? FLIT_TAIL : FLIT_BODY, 64'hD0 + i), "t4_payload");
      checkOutput("t4_busy_after_tail", busy, 0);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("t4_err_dest_count", err_dest_cnt - edest_base, 1);
      checkOutput("t4_meta_count", meta_q.size() - meta_base, 0);
      checkOutput("t4_beat_count", beat_q.size() - beat_base, 0);

      $display("[TB] short packet length error");
      beat_base = beat_q.size();
      elen_base = err_len_cnt;
      applyStimulus(mk_head(FLIT_HEAD, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 4'd2, 8'd3), "t5_head");
      applyStimulus(mk_flit(FLIT_BODY, 64'hE0), "t5_body");
      applyStimulus(mk_flit(FLIT_TAIL, 64'hE1), "t5_tail");
      checkOutput("t5_err_len_pulse", err_len, 1);
      checkOutput("t5_tail_last", data_last, 1);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("t5_err_len_count", err_len_cnt - elen_base, 1);
      verifyBeats("t5", beat_base, 2, 64'hE0);
`endif

      $display("[TB] reset in the middle of a packet");
      applyStimulus(mk_head(FLIT_HEAD, 2'd2, 2'd2, 2'd1, 2'd2, 2'd0, 4'd3, 8'd3), "t6_head");
      data_ready = 1'b0;
      applyStimulus(mk_flit(FLIT_BODY, 64'hC0), "t6_body0");
      applyStimulus(mk_flit(FLIT_BODY, 64'hC1), "t6_body1");
      checkOutput("t6_pre_rst_data_valid", data_valid, 1);
      rst = 1'b1;
      #1;
      checkOutput("t6_rst_data_valid", data_valid, 0);
      checkOutput("t6_rst_data", data, 0);
      checkOutput("t6_rst_busy", busy, 0);
      checkOutput("t6_rst_flit_in_ready", flit_in_ready, 0);
      checkOutput("t6_rst_meta_valid", meta_valid, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      data_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      beat_base = beat_q.size();
      meta_base = meta_q.size();
      elen_base = err_len_cnt;
      applyStimulus(mk_flit(FLIT_BODY, 64'hC2), "t6_stray_body");
      checkOutput("t6_stray_body_err", err_len, 1);
      applyStimulus(mk_flit(FLIT_TAIL, 64'hC3), "t6_stray_tail");
      checkOutput("t6_stray_tail_err", err_len, 1);
      checkOutput("t6_stray_busy", busy, 0);
      applyStimulus(mk_head(FLIT_HEAD, 2'd1, 2'd3, 2'd1, 2'd2, 2'd2, 4'd7, 8'd0), "t6_next_head");
      applyStimulus(mk_flit(FLIT_TAIL, 64'hF0), "t6_next_tail");
      repeat (4) @(posedge clk);
      #1;
      checkOutput("t6_err_len_count", err_len_cnt - elen_base, 2);
      verifyBeats("t6", beat_base, 1, 64'hF0);
      checkOutput("t6_meta_count", meta_q.size() - meta_base, 1);
      if (meta_base < meta_q.size())
         checkOutput("t6_meta_fields", meta_q[meta_base], {2'd1, 2'd3, 2'd2, 4'd7, 8'd0});

`ifndef NOC_DEPKT_CHECK_EN
      checkOutput("no_err_dest_without_checks", err_dest_cnt, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
